// File: rtl/rr_arb_hold.sv
// rr_arb_hold: registered round-robin arbiter, grant held until acknowledged.
// Optional burst lock (i_lock port) enabled by defining RR_ARB_HOLD_LOCK_EN.
module rr_arb_hold #(
  parameter  int W     = 4,
  localparam int IDX_W = $clog2(W)
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [W-1:0]     i_req,
  input  logic             i_ack,
`ifdef RR_ARB_HOLD_LOCK_EN
  input  logic             i_lock,
`endif
  output logic [W-1:0]     o_gnt,
  output logic             o_gnt_vld,
  output logic [IDX_W-1:0] o_gnt_idx
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e           state_q;
  logic [W-1:0]     gnt_q;
  logic             vld_q;
  logic [IDX_W-1:0] idx_q;
  logic [W-1:0]     pm_q;

  logic [W-1:0]     nreq_d;
  logic [W-1:0]     pm_d;
  logic [W-1:0]     gnt_idle_d;
  logic [W-1:0]     gnt_next_d;
  logic             lock_hit_d;

  function automatic logic [W-1:0] lsb(
    input logic [W-1:0] x
  );
    return x & (~x + W'(1));
  endfunction

  // Masked pick first; an empty mask wraps to the lowest raw requester.
  function automatic logic [W-1:0] arb(
    input logic [W-1:0] req,
    input logic [W-1:0] pm
  );
    logic [W-1:0] m;
    m = req & pm;
    if (|m) return lsb(m);
    return lsb(req);
  endfunction

  function automatic logic [IDX_W-1:0] enc(
    input logic [W-1:0] oh
  );
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      if (oh[i]) r = r | i[IDX_W-1:0];
    end
    return r;
  endfunction

  // Next arbitration candidates and the rotated priority mask.
  always_comb begin
    nreq_d     = i_req & ~gnt_q;
    pm_d       = ~(gnt_q | (gnt_q - W'(1)));
    gnt_idle_d = arb(i_req, pm_q);
    gnt_next_d = arb(nreq_d, pm_d);
`ifdef RR_ARB_HOLD_LOCK_EN
    lock_hit_d = i_lock & (|(i_req & gnt_q));
`else
    lock_hit_d = 1'b0;
`endif
  end

  // Grant FSM with registered grant, valid, index and priority mask.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      idx_q   <= '0;
      pm_q    <= '1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|i_req) begin
            state_q <= GRANT;
            gnt_q   <= gnt_idle_d;
            vld_q   <= 1'b1;
            idx_q   <= enc(gnt_idle_d);
          end
        end
        GRANT: begin
          if (i_ack && !lock_hit_d) begin
            pm_q <= pm_d;
            if (|nreq_d) begin
              gnt_q <= gnt_next_d;
              idx_q <= enc(gnt_next_d);
            end else begin
              state_q <= IDLE;
              gnt_q   <= '0;
              vld_q   <= 1'b0;
              idx_q   <= '0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          vld_q   <= 1'b0;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign o_gnt     = gnt_q;
  assign o_gnt_vld = vld_q;
  assign o_gnt_idx = idx_q;

endmodule
